dmem_arbiter: RTL and testbench
===============================

DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 64, width of all data buses.
REQ-002 SHALL have parameter ADDR_WIDTH, default 8, data-memory word address width.
REQ-003 SHALL have parameter MAX_WAIT, default 4, number of host wait cycles before host gets forced priority (1..15).
REQ-004 SHALL have port clk  input  1  the single clock; all logic on its rising edge.
REQ-005 SHALL have port reset_n  input  1  reset, asynchronous and active-low.
REQ-006 SHALL have ports cpu_req / cpu_we  input  1 / 1  MEM-stage access request / write qualifier.
REQ-007 SHALL have ports cpu_addr / cpu_wdata  input  ADDR_WIDTH / DATA_WIDTH  MEM-stage address / store data.
REQ-008 SHALL have ports cpu_rdata / cpu_stall  output  DATA_WIDTH / 1  load data / pipeline stall (holds all stage registers).
REQ-009 SHALL have ports host_req / host_we  input  1 / 1  host (packet side) request / write qualifier; held until host_ack.
REQ-010 SHALL have ports host_addr / host_wdata  input  ADDR_WIDTH / DATA_WIDTH  host address / write data.
REQ-011 SHALL have ports host_rdata / host_ack  output  DATA_WIDTH / 1  host read data / one-cycle completion pulse.
REQ-012 SHALL have ports mem_addr / mem_we / mem_wdata  output  ADDR_WIDTH / 1 / DATA_WIDTH  single-port memory drive.
REQ-013 SHALL have port mem_rdata  input  DATA_WIDTH  memory read data, valid one cycle after address (synchronous read).

Function
REQ-014 SHALL implement FSM states IDLE, CPU_RD, HOST_RD; new accesses issue only in IDLE.
REQ-015 SHALL, in IDLE, grant the CPU when cpu_req=1, unless host is forced (REQ-021), then grant host; grant host when only host_req=1.
REQ-016 SHALL drive mem_addr/mem_we/mem_wdata combinationally from the granted requester in the grant cycle; otherwise mem_we=0, mem_addr/mem_wdata=0.
REQ-017 SHALL complete a granted write in the grant cycle: CPU write -> cpu_stall=0 that cycle; host write -> host_ack=1 that cycle; FSM stays IDLE.
REQ-018 SHALL, on a granted read, move to CPU_RD/HOST_RD; next cycle present mem_rdata on cpu_rdata (cpu_stall=0) or host_rdata (host_ack=1), then return to IDLE.
REQ-019 SHALL assert cpu_stall=1 whenever cpu_req=1 and the CPU access does not complete in that cycle (read grant cycle, host served, HOST_RD).
REQ-020 SHALL hold cpu_rdata and host_rdata at their last captured value between completions.
REQ-021 SHALL keep a saturating wait counter: +1 each cycle host_req=1 without host grant, saturates at MAX_WAIT, clears on host grant; host forced when counter==MAX_WAIT.
REQ-022 SHALL ignore requesters whose req falls before completion; an outstanding read still completes its state and ack/stall behaviour.
REQ-023 SHALL give back-to-back CPU reads a throughput of one per two cycles; back-to-back writes one per cycle.

Reset
REQ-024 SHALL, on reset_n=0, immediately enter IDLE, clear wait counter, cpu_rdata=0, host_rdata=0, host_ack=0; cpu_stall follows REQ-019 from IDLE.
REQ-025 SHALL abandon an in-flight read on reset with no ack or data update; operation resumes on first clock after reset_n rises.

Configuration
REQ-026 SHALL, with macro DMEM_ARB_STARVE_EN defined, implement the wait counter and forced host priority of REQ-021.
REQ-027 SHALL, without DMEM_ARB_STARVE_EN, use strict CPU priority with no counter; host served only in IDLE cycles with cpu_req=0.

Verification
REQ-028 SHALL cover: CPU write addr 0x10 data 0xA5 -> mem_we=1 same cycle, cpu_stall=0.
REQ-029 SHALL cover: CPU read addr 0x10 -> cpu_stall=1 cycle 0, cpu_rdata=0xA5 and cpu_stall=0 cycle 1.
REQ-030 SHALL cover: host and CPU requests same cycle -> CPU granted, host_ack later; host_ack never overlaps CPU completion.
REQ-031 SHALL cover: STARVE_EN, MAX_WAIT=4, cpu_req held high with writes, host_req high -> host granted after exactly 4 wait cycles, cpu_stall=1 during host grant.
REQ-032 SHALL cover: reset_n pulsed low in HOST_RD -> no host_ack, host_rdata=0, FSM IDLE.
REQ-033 SHALL cover: without STARVE_EN, same stimulus as REQ-031 -> host never granted while cpu_req=1.

Source files
------------

// File: rtl/dmem_arbiter.sv
// Data-memory arbiter: shares one synchronous-read single-port RAM between
// the CPU MEM stage and a host (packet-side) requester.
// Optional macro DMEM_ARB_STARVE_EN adds a host wait counter that forces a
// host grant after MAX_WAIT lost cycles; without it the CPU has strict priority.
module dmem_arbiter #(
  parameter int unsigned DATA_WIDTH = 64,
  parameter int unsigned ADDR_WIDTH = 8,
  parameter int unsigned MAX_WAIT   = 4
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  cpu_req,
  input  logic                  cpu_we,
  input  logic [ADDR_WIDTH-1:0] cpu_addr,
  input  logic [DATA_WIDTH-1:0] cpu_wdata,
  output logic [DATA_WIDTH-1:0] cpu_rdata,
  output logic                  cpu_stall,
  input  logic                  host_req,
  input  logic                  host_we,
  input  logic [ADDR_WIDTH-1:0] host_addr,
  input  logic [DATA_WIDTH-1:0] host_wdata,
  output logic [DATA_WIDTH-1:0] host_rdata,
  output logic                  host_ack,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic                  mem_we,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata
);

  localparam int unsigned WAIT_W = 4;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CPU_RD  = 2'd1,
    HOST_RD = 2'd2
  } state_t;

  state_t                state, state_nxt;
  logic                  cpu_grant;
  logic                  host_grant;
  logic                  host_forced;
  logic [DATA_WIDTH-1:0] cpu_rdata_q;
  logic [DATA_WIDTH-1:0] host_rdata_q;

  // State register; reset abandons any in-flight read
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  // Grant decision, memory drive, completion signalling and next state
  always_comb begin
    state_nxt  = state;
    cpu_grant  = 1'b0;
    host_grant = 1'b0;
    mem_addr   = '0;
    mem_we     = 1'b0;
    mem_wdata  = '0;
    cpu_stall  = 1'b0;
    host_ack   = 1'b0;
    cpu_rdata  = cpu_rdata_q;
    host_rdata = host_rdata_q;
    case (state)
      IDLE: begin
        // No access is issued while reset is held
        if (reset_n) begin
          if (cpu_req && !(host_req && host_forced)) cpu_grant  = 1'b1;
          else if (host_req)                         host_grant = 1'b1;
        end
        if (cpu_grant) begin
          mem_addr  = cpu_addr;
          mem_we    = cpu_we;
          mem_wdata = cpu_wdata;
          if (!cpu_we) state_nxt = CPU_RD;
        end else if (host_grant) begin
          mem_addr  = host_addr;
          mem_we    = host_we;
          mem_wdata = host_wdata;
          host_ack  = host_we;
          if (!host_we) state_nxt = HOST_RD;
        end
        cpu_stall = cpu_req && !(cpu_grant && cpu_we);
      end
      CPU_RD: begin
        cpu_rdata = mem_rdata;
        state_nxt = IDLE;
      end
      HOST_RD: begin
        host_rdata = mem_rdata;
        host_ack   = 1'b1;
        cpu_stall  = cpu_req;
        state_nxt  = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Read data holding registers, updated only when a read completes
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cpu_rdata_q  <= '0;
      host_rdata_q <= '0;
    end else begin
      if (state == CPU_RD)  cpu_rdata_q  <= mem_rdata;
      if (state == HOST_RD) host_rdata_q <= mem_rdata;
    end
  end

`ifdef DMEM_ARB_STARVE_EN
  localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(MAX_WAIT);

  logic [WAIT_W-1:0] wait_cnt;

  // Saturating count of cycles the host spent waiting for a grant
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wait_cnt <= '0;
    end else if (host_grant) begin
      wait_cnt <= '0;
    end else if (host_req && (state != HOST_RD) && (wait_cnt != WAIT_MAX)) begin
      wait_cnt <= wait_cnt + WAIT_W'(1);
    end
  end

  assign host_forced = (wait_cnt == WAIT_MAX);
`else
  // Legal MAX_WAIT is never zero, so the host is never forced
  assign host_forced = (MAX_WAIT == 0);
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a synchronous-read RAM model.
// Define DMEM_ARB_STARVE_EN for both files to exercise forced host priority.
module tb_dmem_arbiter;

  localparam int unsigned DW = 64;
  localparam int unsigned AW = 8;
`ifdef DMEM_ARB_STARVE_EN
  localparam bit STARVE = 1'b1;
`else
  localparam bit STARVE = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          cpu_req, cpu_we, host_req, host_we;
  logic [AW-1:0] cpu_addr, host_addr, mem_addr;
  logic [DW-1:0] cpu_wdata, host_wdata, cpu_rdata, host_rdata, mem_wdata, mem_rdata;
  logic          cpu_stall, host_ack, mem_we;

  logic [DW-1:0] ram [256];

  int checks = 0;
  int errors = 0;

  dmem_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .MAX_WAIT(4)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .cpu_req    (cpu_req),
    .cpu_we     (cpu_we),
    .cpu_addr   (cpu_addr),
    .cpu_wdata  (cpu_wdata),
    .cpu_rdata  (cpu_rdata),
    .cpu_stall  (cpu_stall),
    .host_req   (host_req),
    .host_we    (host_we),
    .host_addr  (host_addr),
    .host_wdata (host_wdata),
    .host_rdata (host_rdata),
    .host_ack   (host_ack),
    .mem_addr   (mem_addr),
    .mem_we     (mem_we),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata)
  );

  always #5 clk = ~clk;

  // Single-port RAM, one cycle read latency
  always @(posedge clk) begin
    if (mem_we) ram[mem_addr] <= mem_wdata;
    mem_rdata <= ram[mem_addr];
  end

  typedef struct {
    logic          cr, cw;
    logic [AW-1:0] ca;
    logic [DW-1:0] cd;
    logic          hr, hw;
    logic [AW-1:0] ha;
    logic [DW-1:0] hd;
    logic          e_mwe;
    logic [AW-1:0] e_maddr;
    logic          e_stall, e_hack;
    logic [DW-1:0] e_crd, e_hrd;
  } vec_t;

  localparam int NV = 18;
  vec_t vecs [NV];

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic cr, cw, input logic [AW-1:0] ca, input logic [DW-1:0] cd,
                       input logic hr, hw, input logic [AW-1:0] ha, input logic [DW-1:0] hd);
    cpu_req = cr; cpu_we = cw; cpu_addr = ca; cpu_wdata = cd;
    host_req = hr; host_we = hw; host_addr = ha; host_wdata = hd;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  logic [AW-1:0] ca;
  logic          forced_c, read_c, exp_stall;

  initial begin
    for (int i = 0; i < 256; i++) ram[i] = '0;
    drive(0, 0, 0, 0, 0, 0, 0, 0);

    //           cr cw ca     cd       hr hw ha     hd      mwe maddr  stl ack crd     hrd
    vecs[0]  = '{1, 1, 8'h10, 64'hA5, 0, 0, 8'h00, 64'h00, 1, 8'h10, 0, 0, 64'h00, 64'h00};
    vecs[1]  = '{1, 0, 8'h10, 64'h00, 0, 0, 8'h00, 64'h00, 0, 8'h10, 1, 0, 64'h00, 64'h00};
    vecs[2]  = '{1, 0, 8'h10, 64'h00, 0, 0, 8'h00, 64'h00, 0, 8'h00, 0, 0, 64'hA5, 64'h00};
    vecs[3]  = '{1, 1, 8'h20, 64'h5A, 1, 0, 8'h10, 64'h00, 1, 8'h20, 0, 0, 64'hA5, 64'h00};
    vecs[4]  = '{0, 0, 8'h00, 64'h00, 1, 0, 8'h10, 64'h00, 0, 8'h10, 0, 0, 64'hA5, 64'h00};
    vecs[5]  = '{1, 0, 8'h20, 64'h00, 1, 0, 8'h10, 64'h00, 0, 8'h00, 1, 1, 64'hA5, 64'hA5};
    vecs[6]  = '{1, 0, 8'h20, 64'h00, 0, 0, 8'h00, 64'h00, 0, 8'h20, 1, 0, 64'hA5, 64'hA5};
    vecs[7]  = '{1, 0, 8'h20, 64'h00, 1, 1, 8'h30, 64'h77, 0, 8'h00, 0, 0, 64'h5A, 64'hA5};
    vecs[8]  = '{0, 0, 8'h00, 64'h00, 1, 1, 8'h30, 64'h77, 1, 8'h30, 0, 1, 64'h5A, 64'hA5};
    vecs[9]  = '{1, 1, 8'h31, 64'h11, 0, 0, 8'h00, 64'h00, 1, 8'h31, 0, 0, 64'h5A, 64'hA5};
    vecs[10] = '{1, 1, 8'h32, 64'h22, 0, 0, 8'h00, 64'h00, 1, 8'h32, 0, 0, 64'h5A, 64'hA5};
    vecs[11] = '{0, 0, 8'h00, 64'h00, 0, 0, 8'h00, 64'h00, 0, 8'h00, 0, 0, 64'h5A, 64'hA5};
    vecs[12] = '{0, 0, 8'h00, 64'h00, 1, 0, 8'h30, 64'h00, 0, 8'h30, 0, 0, 64'h5A, 64'hA5};
    vecs[13] = '{0, 0, 8'h00, 64'h00, 1, 0, 8'h30, 64'h00, 0, 8'h00, 0, 1, 64'h5A, 64'h77};
    vecs[14] = '{0, 0, 8'h00, 64'h00, 0, 0, 8'h00, 64'h00, 0, 8'h00, 0, 0, 64'h5A, 64'h77};
    vecs[15] = '{1, 0, 8'h31, 64'h00, 0, 0, 8'h00, 64'h00, 0, 8'h31, 1, 0, 64'h5A, 64'h77};
    vecs[16] = '{0, 0, 8'h00, 64'h00, 0, 0, 8'h00, 64'h00, 0, 8'h00, 0, 0, 64'h11, 64'h77};
    vecs[17] = '{0, 0, 8'h00, 64'h00, 0, 0, 8'h00, 64'h00, 0, 8'h00, 0, 0, 64'h11, 64'h77};

    // Reset state
    next_cycle();
    next_cycle();
    check("rst_stall", DW'(cpu_stall), 0);
    check("rst_ack", DW'(host_ack), 0);
    check("rst_mwe", DW'(mem_we), 0);
    check("rst_crd", cpu_rdata, 0);
    check("rst_hrd", host_rdata, 0);
    reset_n = 1'b1;
    next_cycle();

    // One vector per clock cycle, outputs sampled mid-cycle
    for (int i = 0; i < NV; i++) begin
      drive(vecs[i].cr, vecs[i].cw, vecs[i].ca, vecs[i].cd,
            vecs[i].hr, vecs[i].hw, vecs[i].ha, vecs[i].hd);
      #3;
      check($sformatf("v%0d_mwe", i), DW'(mem_we), DW'(vecs[i].e_mwe));
      check($sformatf("v%0d_maddr", i), DW'(mem_addr), DW'(vecs[i].e_maddr));
      check($sformatf("v%0d_stall", i), DW'(cpu_stall), DW'(vecs[i].e_stall));
      check($sformatf("v%0d_ack", i), DW'(host_ack), DW'(vecs[i].e_hack));
      check($sformatf("v%0d_crd", i), cpu_rdata, vecs[i].e_crd);
      check($sformatf("v%0d_hrd", i), host_rdata, vecs[i].e_hrd);
      next_cycle();
    end

    // Reset pulse while a host read is in flight
    drive(0, 0, 0, 0, 1, 0, 8'h32, 0);
    #3;
    check("hrd_grant_maddr", DW'(mem_addr), 64'h32);
    next_cycle();
    check("hrd_inflight_ack", DW'(host_ack), 1);
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    reset_n = 1'b0;
    #1;
    check("hrd_rst_ack", DW'(host_ack), 0);
    check("hrd_rst_hrd", host_rdata, 0);
    check("hrd_rst_crd", cpu_rdata, 0);
    next_cycle();
    reset_n = 1'b1;
    #2;
    check("hrd_post_ack", DW'(host_ack), 0);
    check("hrd_post_hrd", host_rdata, 0);
    next_cycle();
    drive(1, 1, 8'h33, 64'h33, 0, 0, 0, 0);
    #3;
    check("post_rst_idle_mwe", DW'(mem_we), 1);
    check("post_rst_idle_stall", DW'(cpu_stall), 0);
    next_cycle();

    // CPU streams writes while host holds a read request
    ca = 8'h40;
    for (int c = 0; c < 8; c++) begin
      forced_c  = STARVE && (c == 4);
      read_c    = STARVE && (c == 5);
      exp_stall = forced_c || read_c;
      drive(1, 1, ca, DW'(ca), STARVE ? (c <= 5) : 1'b1, 0, 8'h10, 0);
      #3;
      check($sformatf("st%0d_maddr", c), DW'(mem_addr),
            forced_c ? 64'h10 : (read_c ? 64'h0 : DW'(ca)));
      check($sformatf("st%0d_mwe", c), DW'(mem_we), DW'(!exp_stall));
      check($sformatf("st%0d_stall", c), DW'(cpu_stall), DW'(exp_stall));
      check($sformatf("st%0d_ack", c), DW'(host_ack), DW'(read_c));
      next_cycle();
      if (!exp_stall) ca = ca + 8'd1;
    end

`ifndef DMEM_ARB_STARVE_EN
    // Host only gets in once the CPU goes quiet
    drive(0, 0, 0, 0, 1, 0, 8'h10, 0);
    #3;
    check("strict_host_grant", DW'(mem_addr), 64'h10);
    check("strict_host_ack0", DW'(host_ack), 0);
    next_cycle();
    check("strict_host_ack1", DW'(host_ack), 1);
    check("strict_host_rdata", host_rdata, 64'hA5);
    next_cycle();
`endif
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    next_cycle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
